// File: rtl/ff_mem_pkg.sv
// Types and default widths shared by the RAM port arbiter and the sweep engines.
package ff_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_T    = 2'd1,
    OWN_H    = 2'd2
  } owner_t;

  localparam int FF_ADDR_W = 20;
  localparam int FF_DATA_W = 16;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the test engine (T) and the host (H).
// Grant appears the cycle after a request from idle; read data returns one cycle after its grant.
module ram_port_arbiter
  import ff_mem_pkg::*;
#(
  parameter int ADDR_W    = FF_ADDR_W,
  parameter int DATA_W    = FF_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              test_mode,
  input  logic              t_req,
  input  logic              t_we,
  input  logic [ADDR_W-1:0] t_addr,
  input  logic [DATA_W-1:0] t_wdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              t_gnt,
  output logic              h_gnt,
  output logic              t_rvalid,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] t_rdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output owner_t            owner,
  output logic [15:0]       h_blocked_cnt
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  owner_t     state;
  owner_t     state_nxt;
  logic [7:0] burst_cnt;
  logic       last_t;
  logic       burst_hit;

  assign owner     = state;
  assign burst_hit = (burst_cnt == BURST_LAST);

  always_comb begin
    state_nxt        = state;
    t_gnt            = 1'b0;
    h_gnt            = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;

    case (state)
      OWN_T: begin
        t_gnt            = t_req;
        mem_write_enable = t_we && t_req;
        mem_addr         = t_addr;
        mem_wdata        = t_wdata;
      end
      OWN_H: begin
        h_gnt            = h_req;
        mem_write_enable = h_we && h_req;
        mem_addr         = h_addr;
        mem_wdata        = h_wdata;
      end
      default: ;
    endcase

    case (state)
      OWN_NONE: begin
        if (test_mode)
          state_nxt = t_req ? OWN_T : OWN_NONE;
        else if (t_req && h_req)
          state_nxt = last_t ? OWN_H : OWN_T;
        else if (t_req)
          state_nxt = OWN_T;
        else if (h_req)
          state_nxt = OWN_H;
      end
      // test_mode preempts the host regardless of how far into its burst it is
      OWN_H: begin
        if (test_mode || !h_req)
          state_nxt = t_req ? OWN_T : OWN_NONE;
        else if (burst_hit && t_req)
          state_nxt = OWN_T;
      end
      OWN_T: begin
        if (!t_req)
          state_nxt = (h_req && !test_mode) ? OWN_H : OWN_NONE;
        else if (!test_mode && burst_hit && h_req)
          state_nxt = OWN_H;
      end
      default: state_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= OWN_NONE;
      burst_cnt <= '0;
      last_t    <= 1'b0;
    end else begin
      state <= state_nxt;
      // saturate at the limit so a lone owner keeps the port indefinitely
      if (state_nxt != state)
        burst_cnt <= '0;
      else if ((t_gnt || h_gnt) && !burst_hit)
        burst_cnt <= burst_cnt + 8'd1;
      if (t_gnt)
        last_t <= 1'b1;
      else if (h_gnt)
        last_t <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_rvalid      <= 1'b0;
      h_rvalid      <= 1'b0;
      t_rdata       <= '0;
      h_rdata       <= '0;
      h_blocked_cnt <= '0;
    end else begin
      t_rvalid <= t_gnt && !t_we;
      h_rvalid <= h_gnt && !h_we;
      if (t_gnt && !t_we)
        t_rdata <= mem_rdata;
      if (h_gnt && !h_we)
        h_rdata <= mem_rdata;
      if (h_req && !h_gnt && (h_blocked_cnt != 16'hFFFF))
        h_blocked_cnt <= h_blocked_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a behavioural ownership model.
module tb_ram_port_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        test_mode;
  logic        t_req, t_we, h_req, h_we;
  logic [19:0] t_addr, h_addr;
  logic [15:0] t_wdata, h_wdata;
  logic        t_gnt, h_gnt, t_rvalid, h_rvalid;
  logic [15:0] t_rdata, h_rdata;
  logic        mem_write_enable;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  owner;
  logic [15:0] h_blocked_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(20), .DATA_W(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .test_mode(test_mode),
    .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .t_gnt(t_gnt), .h_gnt(h_gnt), .t_rvalid(t_rvalid), .h_rvalid(h_rvalid),
    .t_rdata(t_rdata), .h_rdata(h_rdata),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .h_blocked_cnt(h_blocked_cnt)
  );

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hA5A5;
    if (i == 5)  return 16'h1234;
    return 16'(i * 257) ^ 16'h5A3C;
  endfunction

  // RAM attached to the DUT
  logic [15:0] ram [0:255];
  logic        do_preload;
  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_write_enable) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // Behavioural model: who owns the port, how many grants in this tenure, who was served last
  logic [15:0] mram [0:255];
  int          m_owner;
  int          m_streak;
  bit          m_last_t;
  int          m_blocked;
  bit          m_tval, m_hval;
  logic [15:0] m_trd, m_hrd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_last_t = 1'b0; m_blocked = 0;
    m_tval = 1'b0; m_hval = 1'b0; m_trd = '0; m_hrd = '0;
  endtask

  task automatic compare();
    bit          e_tg, e_hg, e_we;
    logic [19:0] e_addr;
    logic [15:0] e_wd;
    e_tg   = t_req && (m_owner == 1);
    e_hg   = h_req && (m_owner == 2);
    e_we   = (e_tg && t_we) || (e_hg && h_we);
    e_addr = (m_owner == 1) ? t_addr  : (m_owner == 2) ? h_addr  : 20'd0;
    e_wd   = (m_owner == 1) ? t_wdata : (m_owner == 2) ? h_wdata : 16'd0;
    check("t_gnt", 32'(t_gnt), 32'(e_tg));
    check("h_gnt", 32'(h_gnt), 32'(e_hg));
    check("mem_we", 32'(mem_write_enable), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    check("owner", 32'(owner), 32'(m_owner));
    check("t_rvalid", 32'(t_rvalid), 32'(m_tval));
    check("h_rvalid", 32'(h_rvalid), 32'(m_hval));
    check("t_rdata", 32'(t_rdata), 32'(m_trd));
    check("h_rdata", 32'(h_rdata), 32'(m_hrd));
    check("h_blocked_cnt", 32'(h_blocked_cnt), 32'(m_blocked));
  endtask

  task automatic step();
    bit e_tg, e_hg;
    int nxt;
    e_tg = t_req && (m_owner == 1);
    e_hg = h_req && (m_owner == 2);
    m_tval = e_tg && !t_we;
    m_hval = e_hg && !h_we;
    if (m_tval) m_trd = mram[t_addr[7:0]];
    if (m_hval) m_hrd = mram[h_addr[7:0]];
    if (e_tg && t_we) mram[t_addr[7:0]] = t_wdata;
    if (e_hg && h_we) mram[h_addr[7:0]] = h_wdata;
    if (h_req && !e_hg && m_blocked < 65535) m_blocked++;

    nxt = m_owner;
    if (m_owner == 0) begin
      if (test_mode)          nxt = t_req ? 1 : 0;
      else if (t_req && h_req) nxt = m_last_t ? 2 : 1;
      else                     nxt = t_req ? 1 : (h_req ? 2 : 0);
    end else if (m_owner == 2) begin
      if (test_mode || !h_req)             nxt = t_req ? 1 : 0;
      else if (m_streak + 1 >= MAXB && t_req) nxt = 1;
    end else begin
      if (!t_req)                                      nxt = (h_req && !test_mode) ? 2 : 0;
      else if (!test_mode && m_streak + 1 >= MAXB && h_req) nxt = 2;
    end

    if (e_tg) m_last_t = 1'b1;
    if (e_hg) m_last_t = 1'b0;
    m_streak = (nxt != m_owner) ? 0 : m_streak + ((e_tg || e_hg) ? 1 : 0);
    m_owner  = nxt;
  endtask

  // Drive one cycle of inputs, check, advance model; return just after the next falling edge.
  task automatic cycle(input logic tm,
                       input logic tr, input logic twe, input logic [19:0] ta, input logic [15:0] twd,
                       input logic hr, input logic hwe, input logic [19:0] ha, input logic [15:0] hwd);
    test_mode = tm;
    t_req = tr; t_we = twe; t_addr = ta; t_wdata = twd;
    h_req = hr; h_we = hwe; h_addr = ha; h_wdata = hwd;
    #1;
    compare();
    step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    test_mode = 1'b0; t_req = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    do_preload = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) mram[i] = init_val(i);
    model_reset();
    @(negedge clk);
    #1;
    do_preload = 1'b0;
    compare();
    check("rst_owner_none", 32'(owner), 32'd0);
    check("rst_blocked_zero", 32'(h_blocked_cnt), 32'd0);
    reset = 1'b0;

    // Single T read from idle
    cycle(0, 1, 0, 20'h00010, 16'h0, 0, 0, 20'h0, 16'h0);
    check("t1_gnt_second_cycle", 32'(t_gnt), 32'd1);
    cycle(0, 1, 0, 20'h00010, 16'h0, 0, 0, 20'h0, 16'h0);
    check("t1_rvalid", 32'(t_rvalid), 32'd1);
    check("t1_rdata", 32'(t_rdata), 32'hA5A5);
    check("t1_h_rvalid", 32'(h_rvalid), 32'd0);
    check("t1_h_gnt", 32'(h_gnt), 32'd0);
    cycle(0, 0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0);

    // Tie after reset goes to T, then H once T lets go
    idle_inputs();
    reset_pulse();
    cycle(0, 1, 0, 20'h3, 16'h0, 1, 0, 20'h4, 16'h0);
    check("tie_t_first", 32'(t_gnt), 32'd1);
    check("tie_h_waits", 32'(h_gnt), 32'd0);
    cycle(0, 1, 0, 20'h3, 16'h0, 1, 0, 20'h4, 16'h0);
    cycle(0, 0, 0, 20'h3, 16'h0, 1, 0, 20'h4, 16'h0);
    check("tie_h_next", 32'(h_gnt), 32'd1);

    // Continuous contention: bursts of MAXB alternate with no idle bubble
    idle_inputs();
    reset_pulse();
    cycle(0, 1, 0, 20'h11, 16'h0, 1, 0, 20'h22, 16'h0);
    for (int j = 0; j < 3 * MAXB; j++) begin
      check("burst_t_gnt", 32'(t_gnt), 32'(((j / MAXB) % 2) == 0));
      check("burst_h_gnt", 32'(h_gnt), 32'(((j / MAXB) % 2) == 1));
      check("burst_owner_busy", 32'(owner != 2'd0), 32'd1);
      cycle(0, 1, 0, 20'(j), 16'h0, 1, 0, 20'(j + 64), 16'h0);
    end

    // test_mode blocks the host completely
    idle_inputs();
    reset_pulse();
    for (int j = 0; j < 20; j++) begin
      cycle(1, 0, 0, 20'h0, 16'h0, 1, 0, 20'h8, 16'h0);
      check("tm_h_never_gnt", 32'(h_gnt), 32'd0);
    end
    check("tm_blocked_20", 32'(h_blocked_cnt), 32'd20);
    check("tm_owner_none", 32'(owner), 32'd0);

    // Host preempted mid-burst; its write after the handover is not performed
    idle_inputs();
    reset_pulse();
    for (int j = 0; j < 4; j++) cycle(0, 0, 0, 20'h0, 16'h0, 1, 0, 20'h7, 16'h0);
    cycle(1, 1, 0, 20'h9, 16'h0, 1, 0, 20'h7, 16'h0);
    check("preempt_owner_t", 32'(owner), 32'd1);
    cycle(1, 1, 0, 20'h9, 16'h0, 1, 1, 20'h7, 16'hBEEF);
    check("preempt_h_write_dropped", 32'(ram[7]), 32'(init_val(7)));
    cycle(0, 0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0);

    // Reset lands on a T write in flight
    idle_inputs();
    reset_pulse();
    cycle(0, 1, 0, 20'h3, 16'h0, 0, 0, 20'h0, 16'h0);
    cycle(0, 1, 0, 20'h3, 16'h0, 0, 0, 20'h0, 16'h0);
    t_we = 1'b1; t_addr = 20'h5; t_wdata = 16'hFFFF;
    reset = 1'b1;
    #1;
    check("rst_inflight_we", 32'(mem_write_enable), 32'd0);
    model_reset();
    compare();
    @(negedge clk);
    #1;
    reset = 1'b0;
    check("rst_inflight_ram5", 32'(ram[5]), 32'h1234);
    cycle(0, 0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0);
    check("rst_after_owner", 32'(owner), 32'd0);
    check("rst_after_trvalid", 32'(t_rvalid), 32'd0);

    // Randomized traffic
    idle_inputs();
    reset_pulse();
    begin
      logic tm;
      tm = 1'b0;
      for (int j = 0; j < 1500; j++) begin
        if ($urandom_range(0, 99) < 3) tm = ~tm;
        cycle(tm,
              ($urandom_range(0, 99) < 65), 1'($urandom), 20'($urandom_range(0, 255)), 16'($urandom),
              ($urandom_range(0, 99) < 65), 1'($urandom), 20'($urandom_range(0, 255)), 16'($urandom));
      end
    end
    for (int i = 0; i < 256; i++) check("ram_final", 32'(ram[i]), 32'(mram[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
